// File: rtl/prog_mod_counter.sv
// Runtime-programmable up/down modulo counter with load, modulus register and cascade terminal count.
// Optional saturating wrap tally output enabled by defining COUNTER_WRAP_TALLY_EN.
module prog_mod_counter #(
   parameter int unsigned   N           = 8,
   parameter logic [N-1:0]  DEFAULT_MAX = '1,
   parameter int unsigned   WRAP_W      = 16
) (
   input  logic             clk,
   input  logic             asyncReset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [N-1:0]     loadValue,
   input  logic             setMax,
   input  logic [N-1:0]     maxValue,
   output logic [N-1:0]     q,
   output logic             done,
   output logic             tc
`ifdef COUNTER_WRAP_TALLY_EN
   ,
   output logic [WRAP_W-1:0] wrapTally
`endif
);

   // Elaboration-time parameter sanity.
   if (N < 2) begin : g_bad_n
      $error("prog_mod_counter: N must be at least 2");
   end
   if (WRAP_W < 1) begin : g_bad_wrap_w
      $error("prog_mod_counter: WRAP_W must be at least 1");
   end

   logic [N-1:0] max_reg;
   logic [N-1:0] q_nxt;
   logic         done_nxt;
   logic         wrap_up;
   logic         wrap_dn;
   logic         at_wrap;

   // Wrap conditions compared in N bits; q above max_reg is treated as a wrap point.
   assign wrap_up = (q >= max_reg);
   assign wrap_dn = (q == '0) || (q > max_reg);
   assign at_wrap = up ? wrap_up : wrap_dn;

   assign tc = en & ~load & ~asyncReset & at_wrap;

   // Next count: load beats enable; all decisions use the current max_reg.
   always_comb begin
      q_nxt    = q;
      done_nxt = 1'b0;
      if (load) begin
         q_nxt = (loadValue > max_reg) ? max_reg : loadValue;
      end else if (en) begin
         if (at_wrap) begin
            q_nxt    = up ? '0 : max_reg;
            done_nxt = 1'b1;
         end else begin
            q_nxt = up ? (q + N'(1)) : (q - N'(1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (asyncReset) begin
         q       <= '0;
         done    <= 1'b0;
         max_reg <= DEFAULT_MAX;
      end else begin
         q    <= q_nxt;
         done <= done_nxt;
         if (setMax) begin
            max_reg <= maxValue;
         end
      end
   end

`ifdef COUNTER_WRAP_TALLY_EN
   // Saturating count of wrap events; only reset clears it.
   always_ff @(posedge clk) begin
      if (asyncReset) begin
         wrapTally <= '0;
      end else if (done_nxt && (wrapTally != '1)) begin
         wrapTally <= wrapTally + WRAP_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed self-checking bench for prog_mod_counter: single counter plus a two-stage cascade.
module tb_prog_mod_counter;

   localparam int unsigned N  = 4;
   localparam int unsigned WW = 2;

   logic         clk = 1'b0;
   logic         asyncReset;
   logic         en, up, load, setMax;
   logic [N-1:0] loadValue, maxValue;
   logic [N-1:0] q;
   logic         done, tc;
`ifdef COUNTER_WRAP_TALLY_EN
   logic [WW-1:0] wrapTally;
   logic [WW-1:0] tally0, tally1;
`endif

   logic         cen;
   logic [N-1:0] q0, q1;
   logic         done0, done1, tc0, tc1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prog_mod_counter #(.N(N), .WRAP_W(WW)) dut (
      .clk(clk), .asyncReset(asyncReset), .en(en), .up(up), .load(load),
      .loadValue(loadValue), .setMax(setMax), .maxValue(maxValue),
      .q(q), .done(done), .tc(tc)
`ifdef COUNTER_WRAP_TALLY_EN
      , .wrapTally(wrapTally)
`endif
   );

   prog_mod_counter #(.N(N), .WRAP_W(WW)) c0 (
      .clk(clk), .asyncReset(asyncReset), .en(cen), .up(1'b1), .load(1'b0),
      .loadValue(4'd0), .setMax(1'b0), .maxValue(4'd0),
      .q(q0), .done(done0), .tc(tc0)
`ifdef COUNTER_WRAP_TALLY_EN
      , .wrapTally(tally0)
`endif
   );

   prog_mod_counter #(.N(N), .WRAP_W(WW)) c1 (
      .clk(clk), .asyncReset(asyncReset), .en(tc0), .up(1'b1), .load(1'b0),
      .loadValue(4'd0), .setMax(1'b0), .maxValue(4'd0),
      .q(q1), .done(done1), .tc(tc1)
`ifdef COUNTER_WRAP_TALLY_EN
      , .wrapTally(tally1)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; up = 1'b1; load = 1'b0; setMax = 1'b0;
      loadValue = '0; maxValue = '0; cen = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      asyncReset = 1'b1;
      step();
      asyncReset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      if (q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d expected 0", q); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b expected 0", tc); end
      checks++;
   endtask

   task automatic test_count_up();
      logic [N-1:0] eq;
      do_reset();
      en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         eq = 4'(i % 16);
         if (q !== eq) begin errors++; $display("FAIL count_up_q step %0d got %0d expected %0d", i, q, eq); end
         checks++;
         if (done !== (i == 16)) begin errors++; $display("FAIL count_up_done step %0d got %b expected %b", i, done, (i == 16)); end
         checks++;
         if (tc !== (eq == 4'd15)) begin errors++; $display("FAIL count_up_tc step %0d got %b expected %b", i, tc, (eq == 4'd15)); end
         checks++;
      end
   endtask

   task automatic test_set_max();
      logic [N-1:0] exp_q [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2};
      do_reset();
      setMax = 1'b1; maxValue = 4'd5;
      step();
      setMax = 1'b0; en = 1'b1; up = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (q !== exp_q[i]) begin errors++; $display("FAIL setmax_q step %0d got %0d expected %0d", i, q, exp_q[i]); end
         checks++;
         if (done !== (i == 5)) begin errors++; $display("FAIL setmax_done step %0d got %b expected %b", i, done, (i == 5)); end
         checks++;
      end
      // New max applied alongside a count: the count still sees the old max.
      do_reset();
      load = 1'b1; loadValue = 4'd14;
      step();
      load = 1'b0; en = 1'b1; setMax = 1'b1; maxValue = 4'd5;
      step();
      setMax = 1'b0;
      if (q !== 4'd15 || done !== 1'b0) begin errors++; $display("FAIL setmax_oldmax got q=%0d done=%b expected q=15 done=0", q, done); end
      checks++;
      step();
      if (q !== 4'd0 || done !== 1'b1) begin errors++; $display("FAIL setmax_newmax got q=%0d done=%b expected q=0 done=1", q, done); end
      checks++;
   endtask

   task automatic test_count_down();
      logic [N-1:0] exp_q [3] = '{4'd5, 4'd4, 4'd3};
      // Continues from q = 0 with max 5.
      en = 1'b1; up = 1'b0;
      #1;
      if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_at_zero got %b expected 1", tc); end
      checks++;
      for (int i = 0; i < 3; i++) begin
         step();
         if (q !== exp_q[i]) begin errors++; $display("FAIL down_q step %0d got %0d expected %0d", i, q, exp_q[i]); end
         checks++;
         if (done !== (i == 0)) begin errors++; $display("FAIL down_done step %0d got %b expected %b", i, done, (i == 0)); end
         checks++;
      end
      load = 1'b1; loadValue = 4'd9;
      step();
      load = 1'b0;
      if (q !== 4'd5 || done !== 1'b0) begin errors++; $display("FAIL load_clamp got q=%0d done=%b expected q=5 done=0", q, done); end
      checks++;
      // Full-range down wrap from 0 with default max.
      do_reset();
      en = 1'b1; up = 1'b0;
      step();
      if (q !== 4'd15 || done !== 1'b1) begin errors++; $display("FAIL down_full_wrap got q=%0d done=%b expected q=15 done=1", q, done); end
      checks++;
   endtask

   task automatic test_load_hold();
      do_reset();
      en = 1'b1; up = 1'b1; load = 1'b1; loadValue = 4'd3;
      #1;
      if (tc !== 1'b0) begin errors++; $display("FAIL load_tc got %b expected 0", tc); end
      checks++;
      step();
      load = 1'b0; en = 1'b0;
      if (q !== 4'd3 || done !== 1'b0) begin errors++; $display("FAIL load_q got q=%0d done=%b expected q=3 done=0", q, done); end
      checks++;
      for (int i = 0; i < 4; i++) begin
         step();
         if (q !== 4'd3 || done !== 1'b0 || tc !== 1'b0) begin
            errors++; $display("FAIL hold step %0d got q=%0d done=%b tc=%b expected q=3 done=0 tc=0", i, q, done, tc);
         end
         checks++;
      end
      // Direction flips with no dead cycle.
      en = 1'b1; up = 1'b1;
      step();
      up = 1'b0;
      step();
      if (q !== 4'd3) begin errors++; $display("FAIL dir_change got %0d expected 3", q); end
      checks++;
   endtask

   task automatic test_cascade();
      do_reset();
      cen = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 16) begin
            if (q1 !== 4'd1 || q0 !== 4'd0) begin errors++; $display("FAIL cascade16 got %0d:%0d expected 1:0", q1, q0); end
            checks++;
         end
      end
      cen = 1'b0;
      if (q1 !== 4'd2 || q0 !== 4'd8) begin errors++; $display("FAIL cascade40 got %0d:%0d expected 2:8", q1, q0); end
      checks++;
   endtask

`ifdef COUNTER_WRAP_TALLY_EN
   task automatic test_tally();
      int et;
      do_reset();
      setMax = 1'b1; maxValue = 4'd0;
      step();
      setMax = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; loadValue = 4'd0;
      step();
      load = 1'b0;
      if (wrapTally !== 2'd0) begin errors++; $display("FAIL tally_load got %0d expected 0", wrapTally); end
      checks++;
      for (int i = 1; i <= 6; i++) begin
         if (tc !== 1'b1) begin errors++; $display("FAIL tally_tc step %0d got %b expected 1", i, tc); end
         checks++;
         step();
         et = (i > 3) ? 3 : i;
         if (q !== 4'd0 || done !== 1'b1 || wrapTally !== WW'(et)) begin
            errors++; $display("FAIL tally step %0d got q=%0d done=%b tally=%0d expected q=0 done=1 tally=%0d", i, q, done, wrapTally, et);
         end
         checks++;
      end
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      load = 1'b1; loadValue = 4'd9;
      step();
      load = 1'b0; setMax = 1'b1; maxValue = 4'd12;
      step();
      asyncReset = 1'b1; load = 1'b1; loadValue = 4'd7; setMax = 1'b1; maxValue = 4'd2; en = 1'b1;
      #1;
      if (tc !== 1'b0) begin errors++; $display("FAIL reset_mid_tc got %b expected 0", tc); end
      checks++;
      step();
      asyncReset = 1'b0; load = 1'b0; setMax = 1'b0;
      if (q !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL reset_mid got q=%0d done=%b expected q=0 done=0", q, done); end
      checks++;
`ifdef COUNTER_WRAP_TALLY_EN
      if (wrapTally !== 2'd0) begin errors++; $display("FAIL reset_mid_tally got %0d expected 0", wrapTally); end
      checks++;
`endif
      // Down wrap from 0 lands on the default max, not on 12 or 2.
      en = 1'b1; up = 1'b0;
      step();
      if (q !== 4'd15 || done !== 1'b1) begin errors++; $display("FAIL reset_mid_max got q=%0d done=%b expected q=15 done=1", q, done); end
      checks++;
   endtask

   initial begin
      idle_inputs();
      asyncReset = 1'b1;
      test_reset();
      test_count_up();
      test_set_max();
      test_count_down();
      test_load_hold();
      test_cascade();
`ifdef COUNTER_WRAP_TALLY_EN
      test_tally();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_mod_counter.md
Name: prog_mod_counter

Overview:
Runtime-programmable modulo counter for general design use; parametrised successor to the fixed-MAX modulo counter. Adds count enable, up/down direction, synchronous parallel load, and a modulus register written at run time. Keeps the registered wrap pulse `done`. Adds a combinational terminal-count output for cascading counters.

Parameters:
N, 8, counter width in bits (N >= 2).
DEFAULT_MAX, 2**N-1, value written to the modulus register on reset; must fit in N bits.
WRAP_W, 16, width of the wrap tally; used only when COUNTER_WRAP_TALLY_EN is defined.

Ports:
clk  in  1  rising-edge clock; the only clock.
asyncReset  in  1  reset, synchronous and active-high, sampled only on posedge clk; the name is kept for port compatibility with existing counters.
en  in  1  count enable.
up  in  1  direction: 1 = increment, 0 = decrement.
load  in  1  synchronous load strobe.
loadValue  in  N  value to load.
setMax  in  1  modulus-register write strobe.
maxValue  in  N  new modulus (the counter counts 0..maxValue).
q  out  N  count value, registered.
done  out  1  registered one-cycle wrap pulse.
tc  out  1  combinational terminal count: the next enabled count wraps.
wrapTally  out  WRAP_W  saturating wrap count (present only with COUNTER_WRAP_TALLY_EN).

Behaviour:
- All state updates on posedge clk.
- Priority of q/done update: asyncReset > load > en.
- Reset:
  - q = 0, done = 0, maxReg = DEFAULT_MAX.
  - wrapTally = 0.
  - Reset during an in-progress count discards that count with no other effect.
- setMax:
  - maxReg <= maxValue.
  - Independent of load/en and applied in the same cycle.
  - Any count or load evaluated in that cycle uses the OLD maxReg.
  - Ignored while asyncReset = 1.
- load = 1:
  - q <= min(loadValue, maxReg), using the old maxReg.
  - done <= 0. en is ignored that cycle.
- en = 1, up = 1, no load:
  - If q >= maxReg: q <= 0, done <= 1.
  - Otherwise: q <= q + 1, done <= 0.
- en = 1, up = 0, no load:
  - If q == 0 or q > maxReg: q <= maxReg, done <= 1.
  - Otherwise: q <= q - 1, done <= 0.
- en = 0, no load: q holds, done <= 0.
- done:
  - High for exactly the one cycle in which q shows the post-wrap value (0 for up, maxReg for down).
  - Stays high on consecutive cycles only if wraps occur back-to-back (e.g. maxReg = 0).
- tc = en & ~load & ~asyncReset & (up ? (q >= maxReg) : (q == 0 | q > maxReg)).
  - Purely combinational from registered state and inputs.
  - Cascade: tc of a lower stage drives en of the next stage.
- maxReg = 0: q stays 0. Every enabled cycle gives done = 1, and tc = en.
- maxReg = 2**N-1: full natural wrap. Comparisons must be done in N bits with no overflow; no N+1-bit intermediate wraps silently.
- Direction change mid-count: takes effect on the next enabled edge with no dead cycle.

Optional Feature:
COUNTER_WRAP_TALLY_EN
- Defined:
  - The wrapTally port exists.
  - It increments by 1 on every edge where done is set to 1, and saturates at 2**WRAP_W-1.
  - Cleared only by asyncReset; load does not clear it.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then en = 1, up = 1, N = 4, default max 15 for 17 cycles -> q runs 0..15, 0, 1. done = 1 only in the cycle q = 0 after 15. tc = 1 while q = 15.
- setMax = 1 with maxValue = 5, then count up 8 cycles -> q = 1, 2, 3, 4, 5, 0, 1, 2 with a single done pulse. setMax together with en at q = 14 (old max 15) -> q = 15, then next edge 0 with done.
- up = 0 from q = 0, max 5 -> q = 5, 4, 3. done = 1 in the q = 5 cycle. load loadValue = 9 with max 5 -> q = 5.
- load = 1 with en = 1, loadValue = 3 -> q = 3, done = 0. Then en = 0 for 4 cycles -> q holds 3, done = 0, tc = 0.
- Cascade two 4-bit instances (tc of stage 0 -> en of stage 1), 40 cycles -> {q1, q0} = 40 decimal as 2 and 8. With COUNTER_WRAP_TALLY_EN and WRAP_W = 2, maxReg = 0 for 6 cycles -> wrapTally saturates at 3.
- Assert asyncReset for 1 cycle mid-count at q = 9, with load = 1 in the same cycle -> q = 0, maxReg = DEFAULT_MAX, done = 0, wrapTally = 0.
